binary_to_bcd_seq: RTL and testbench

Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per two clocks.
- Successor to the single-shot converter: adds a start/done handshake, a busy indication, overflow detection with saturation, and back-to-back operation.
- Feeds the 7-segment display drivers from counters and score registers.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 16 +
 rtl/binary_to_bcd_seq.sv | 137 +++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: none (package only).
// Backpressure: not applicable.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ADD3  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD_DIGIT_W    = 4;
  localparam int ADD3_THRESHOLD = 5;
  localparam int BCD_MAX_DIGIT  = 9;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell: a digit of 5 or more gets +3 before the next doubling.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Plain 4-bit add; a corrected digit (<=12) never wraps, so no carry is needed.
  assign digit_out = (digit_in >= BCD_DIGIT_W'(ADD3_THRESHOLD))
                   ? digit_in + BCD_DIGIT_W'(3)
                   : digit_in;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle double-dabble converter with start/done handshake and overflow saturation.
// Latency: result (o_DV) 2*INPUT_WIDTH-1 edges after the accepting edge; back-to-back capable.
// Backpressure: i_Start is ignored while o_Busy=1; optional o_Blank under `BCD_LZ_BLANK_EN.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 7,
  parameter int DECIMAL_DIGITS = 2
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset,
  input  logic                                i_Start,
  input  logic [INPUT_WIDTH-1:0]              i_Binary,
  output logic                                o_Busy,
  output logic                                o_DV,
  output logic [DECIMAL_DIGITS*BCD_DIGIT_W-1:0] o_BCD,
  output logic                                o_Overflow
`ifdef BCD_LZ_BLANK_EN
  ,
  output logic [DECIMAL_DIGITS-1:0]           o_Blank
`endif
);

  localparam int BCD_W = DECIMAL_DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam int CAT_W = BCD_W + INPUT_WIDTH;

  state_t             state;
  logic [INPUT_WIDTH-1:0] bin_shift;
  logic [BCD_W-1:0]   bcd_work;
  logic [CNT_W-1:0]   bit_cnt;
  logic               sticky_ovf;

  logic [BCD_W-1:0]   bcd_adj;
  logic [CAT_W-1:0]   cat_shift;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [INPUT_WIDTH-1:0] bin_shifted;
  logic               ovf_next;
  logic [CNT_W-1:0]   cnt_dec;
  logic [BCD_W-1:0]   sat_value;

  // Per-digit +3 correction applied in parallel across the working register.
  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj [g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {bcd_work, bin_shift} shifted left by one; the bcd MSB falls off into the overflow flag.
  assign cat_shift   = {bcd_work[BCD_W-2:0], bin_shift, 1'b0};
  assign bcd_shifted = cat_shift[CAT_W-1:INPUT_WIDTH];
  assign bin_shifted = cat_shift[INPUT_WIDTH-1:0];
  assign ovf_next    = sticky_ovf | bcd_work[BCD_W-1];
  assign cnt_dec     = bit_cnt - CNT_W'(1);
  assign sat_value   = {DECIMAL_DIGITS{BCD_DIGIT_W'(BCD_MAX_DIGIT)}};

`ifdef BCD_LZ_BLANK_EN
  logic [DECIMAL_DIGITS-1:0] blank_calc;
  logic                      higher_zero;

  // Leading-zero mask of the final value; digit 0 is never blanked, saturation blanks nothing.
  always_comb begin
    blank_calc  = '0;
    higher_zero = 1'b1;
    for (int k = DECIMAL_DIGITS - 1; k >= 1; k--) begin
      higher_zero   = higher_zero && (bcd_shifted[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_calc[k] = higher_zero;
    end
    if (ovf_next) begin
      blank_calc = '0;
    end
  end
`endif

  // Control FSM plus datapath registers; all outputs registered here.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      bin_shift  <= '0;
      bcd_work   <= '0;
      bit_cnt    <= '0;
      sticky_ovf <= 1'b0;
      o_Busy     <= 1'b0;
      o_DV       <= 1'b0;
      o_BCD      <= '0;
      o_Overflow <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
      o_Blank    <= '0;
`endif
    end else begin
      o_DV <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_Start) begin
            bin_shift  <= i_Binary;
            bcd_work   <= '0;
            sticky_ovf <= 1'b0;
            bit_cnt    <= CNT_W'(INPUT_WIDTH);
            state      <= ST_SHIFT;
            o_Busy     <= 1'b1;
          end else begin
            state      <= ST_IDLE;
            o_Busy     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          bcd_work   <= bcd_shifted;
          bin_shift  <= bin_shifted;
          sticky_ovf <= ovf_next;
          bit_cnt    <= cnt_dec;
          if (cnt_dec == '0) begin
            state      <= ST_DONE;
            o_Busy     <= 1'b0;
            o_DV       <= 1'b1;
            o_BCD      <= ovf_next ? sat_value : bcd_shifted;
            o_Overflow <= ovf_next;
`ifdef BCD_LZ_BLANK_EN
            o_Blank    <= blank_calc;
`endif
          end else begin
            state      <= ST_ADD3;
          end
        end
        ST_ADD3: begin
          bcd_work <= bcd_adj;
          state    <= ST_SHIFT;
        end
        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq (W=7, D=2) with hand-computed results.
// Latency: checks 14-cycle start-to-result and back-to-back spacing.
// Backpressure: checks that i_Start during busy is ignored; o_Blank checked under `BCD_LZ_BLANK_EN.
module tb_binary_to_bcd_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] binary;
  logic       busy;
  logic       dv;
  logic [7:0] bcd;
  logic       ovf;
`ifdef BCD_LZ_BLANK_EN
  logic [1:0] blank;
`endif

  int n_checks = 0;
  int n_errors = 0;

  binary_to_bcd_seq #(.INPUT_WIDTH(7), .DECIMAL_DIGITS(2)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Start    (start),
    .i_Binary   (binary),
    .o_Busy     (busy),
    .o_DV       (dv),
    .o_BCD      (bcd),
    .o_Overflow (ovf)
`ifdef BCD_LZ_BLANK_EN
    ,
    .o_Blank    (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One start pulse, wait for o_DV (bounded), check latency, busy length and result.
  task automatic convert(input logic [6:0] v, input logic [7:0] exp_bcd,
                         input logic exp_ovf, input logic [1:0] exp_blank);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    binary = v;
    cyc      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cnt++;
    end while (!dv && cyc < 40);
    check($sformatf("latency_%0d", v), cyc, 14);
    check($sformatf("busy_len_%0d", v), busy_cnt, 13);
    check($sformatf("bcd_%0d", v), bcd, exp_bcd);
    check($sformatf("ovf_%0d", v), ovf, exp_ovf);
`ifdef BCD_LZ_BLANK_EN
    check($sformatf("blank_%0d", v), blank, exp_blank);
`else
    if (exp_blank != 2'b11) begin end
`endif
    @(negedge clk);
    check($sformatf("dv_one_cycle_%0d", v), dv, 1'b0);
  endtask

  initial begin
    int gap;
    int dv_seen;

    rst    = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_dv", dv, 1'b0);
    check("reset_bcd", bcd, 8'h00);
    check("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversions, including saturation and recovery.
    convert(7'd10,  8'h10, 1'b0, 2'b00);
    convert(7'd0,   8'h00, 1'b0, 2'b10);
    convert(7'd9,   8'h09, 1'b0, 2'b10);
    convert(7'd99,  8'h99, 1'b0, 2'b00);
    convert(7'd127, 8'h99, 1'b1, 2'b00);
    convert(7'd5,   8'h05, 1'b0, 2'b10);
    convert(7'd100, 8'h99, 1'b1, 2'b00);
    convert(7'd7,   8'h07, 1'b0, 2'b10);
    convert(7'd70,  8'h70, 1'b0, 2'b00);

    // Back-to-back: start held high, second operand presented in the DONE cycle.
    @(negedge clk);
    start  = 1'b1;
    binary = 7'd42;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!dv && gap < 40);
    check("b2b_first_lat", gap, 14);
    check("b2b_first_bcd", bcd, 8'h42);
    binary = 7'd57;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      start = 1'b0;
      if (gap == 5) begin
        check("b2b_bcd_held", bcd, 8'h42);
        start  = 1'b1;
        binary = 7'd3;
      end
    end while (!dv && gap < 40);
    start = 1'b0;
    check("b2b_dv_spacing", gap, 14);
    check("b2b_second_bcd", bcd, 8'h57);
    dv_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dv) dv_seen++;
    end
    check("busy_start_ignored_dv", dv_seen, 0);
    check("busy_start_ignored_bcd", bcd, 8'h57);

    // Reset mid-conversion discards the result.
    @(negedge clk);
    start  = 1'b1;
    binary = 7'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", busy, 1'b0);
    check("midreset_dv", dv, 1'b0);
    check("midreset_bcd", bcd, 8'h00);
    check("midreset_ovf", ovf, 1'b0);
    dv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (dv) dv_seen++;
    end
    check("midreset_no_dv", dv_seen, 0);
    convert(7'd10, 8'h10, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
